boruss_data_mem_responder: RTL and testbench

BORUSS_DATA_MEM_RESPONDER -- requirements
Module: boruss_data_mem_responder

---
 rtl/boruss_data_mem_responder.sv | 129 ++++++++++++
 tb/tb_boruss_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boruss_data_mem_responder.sv
// Data-memory responder: 256-byte loadable ROM plus resettable RAM behind a
// valid/ready request port, answering after a fixed number of wait states.
module boruss_data_mem_responder #(
    parameter int unsigned RAM_DEPTH   = 64,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid_i,
    input  logic       req_write_i,
    input  logic       req_map_select_i,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       req_ready_o,
    output logic       resp_valid_o,
    output logic [7:0] resp_rdata_o,
    output logic       resp_error_o,
    input  logic       prog_we_i,
    input  logic [7:0] prog_addr_i,
    input  logic [7:0] prog_data_i
);

    localparam int unsigned AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        write_q, map_q;
    logic [7:0]  addr_q, wdata_q;
    logic        resp_valid_q, resp_error_q;
    logic [7:0]  resp_rdata_q;
    logic [7:0]  ram_q [RAM_DEPTH];
    logic [7:0]  rom_q [256];

    logic          accept, enter_respond, in_range, acc_error;
    logic          acc_write, acc_map;
    logic [7:0]    acc_addr, acc_wdata, rd_data;
    logic [AW-1:0] ram_idx;

    assign req_ready_o  = (state_q == StIdle) && !prog_we_i;
    assign accept       = req_valid_i && req_ready_o;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_error_o = resp_error_q;

    // With zero wait states the access completes on the accept edge itself,
    // so the live request fields are used instead of the latched copies.
    always_comb begin
        if (state_q == StIdle) begin
            acc_write = req_write_i;
            acc_map   = req_map_select_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
        end else begin
            acc_write = write_q;
            acc_map   = map_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        enter_respond = (accept && WAIT_STATES == 0) || (state_q == StWait && cnt_q == 4'd1);
        in_range      = {24'd0, acc_addr} < RAM_DEPTH;
        ram_idx       = acc_addr[AW-1:0];
        acc_error     = acc_map ? !in_range : acc_write;
        rd_data       = 8'h00;
        if (!acc_error && !acc_write) begin
            rd_data = acc_map ? ram_q[ram_idx] : rom_q[acc_addr];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            map_q        <= 1'b0;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 8'h00;
            resp_error_q <= 1'b0;
            for (int i = 0; i < int'(RAM_DEPTH); i++) begin
                ram_q[i] <= 8'h00;
            end
        end else begin
            resp_valid_q <= enter_respond;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        write_q <= req_write_i;
                        map_q   <= req_map_select_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        if (WAIT_STATES == 0) begin
                            state_q <= StRespond;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitLoad;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StRespond;
                    end
                end
                StRespond: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
            if (enter_respond) begin
                resp_rdata_q <= rd_data;
                resp_error_q <= acc_error;
                if (acc_write && acc_map && in_range) begin
                    ram_q[ram_idx] <= acc_wdata;
                end
            end
        end
    end

    // ROM has no reset so its contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (prog_we_i) begin
            rom_q[prog_addr_i] <= prog_data_i;
        end
    end

endmodule

// File: tb/tb_boruss_data_mem_responder.sv
// Bench: two responders (1 and 2 wait states) driven in lockstep and checked
// against an array model of the ROM/RAM access rules.
module tb_boruss_data_mem_responder;

    localparam int unsigned Depth = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_write, req_map, prog_we;
    logic [7:0] req_addr, req_wdata, prog_addr, prog_data;
    logic       ready1, valid1, err1, ready2, valid2, err2;
    logic [7:0] rdata1, rdata2;

    always #5 clk = ~clk;

    boruss_data_mem_responder #(.RAM_DEPTH(Depth), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_write_i(req_write),
        .req_map_select_i(req_map), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(ready1), .resp_valid_o(valid1), .resp_rdata_o(rdata1),
        .resp_error_o(err1), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
        .prog_data_i(prog_data)
    );

    boruss_data_mem_responder #(.RAM_DEPTH(Depth), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_write_i(req_write),
        .req_map_select_i(req_map), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(ready2), .resp_valid_o(valid2), .resp_rdata_o(rdata2),
        .resp_error_o(err2), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
        .prog_data_i(prog_data)
    );

    logic [7:0] ram_m [256];
    logic [7:0] rom_m [256];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void model(input logic wr, input logic map, input logic [7:0] addr,
                                  input logic [7:0] wdata, output logic err,
                                  output logic [7:0] rd);
        rd  = 8'h00;
        err = 1'b0;
        if (map && 32'(addr) < Depth) begin
            if (wr) ram_m[addr] = wdata;
            else    rd = ram_m[addr];
        end else if (map || wr) begin
            err = 1'b1;
        end else begin
            rd = rom_m[addr];
        end
    endfunction

    // Entered one step after the accept edge; response due WAIT_STATES samples later.
    task automatic wait_resp(input logic exp_err, input logic [7:0] exp1, input logic [7:0] exp2);
        int lat1 = 99, lat2 = 99, n1 = 0, n2 = 0;
        logic [7:0] rd1 = 8'h00, rd2 = 8'h00;
        logic e1 = 1'b0, e2 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (valid1) begin n1++; lat1 = j; rd1 = rdata1; e1 = err1; end
            if (valid2) begin n2++; lat2 = j; rd2 = rdata2; e2 = err2; end
            @(posedge clk); #1;
        end
        check_eq("latency1", lat1, 1);
        check_eq("latency2", lat2, 2);
        check_eq("pulses1", n1, 1);
        check_eq("pulses2", n2, 1);
        check_eq("error1", e1, exp_err);
        check_eq("error2", e2, exp_err);
        check_eq("rdata1", rd1, exp1);
        check_eq("rdata2", rd2, exp2);
    endtask

    task automatic issue(input logic wr, input logic map, input logic [7:0] addr,
                         input logic [7:0] wdata);
        req_write = wr; req_map = map; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        #1;
        check_eq("ready1_idle", ready1, 1);
        check_eq("ready2_idle", ready2, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic access(input logic wr, input logic map, input logic [7:0] addr,
                          input logic [7:0] wdata);
        logic e;
        logic [7:0] rd;
        model(wr, map, addr, wdata, e, rd);
        issue(wr, map, addr, wdata);
        wait_resp(e, rd, rd);
    endtask

    task automatic prog_rom(input logic [7:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        rom_m[a] = d;
    endtask

    task automatic random_accesses(input int n);
        logic wr, map;
        logic [7:0] addr;
        repeat (n) begin
            if ($urandom_range(0, 9) == 0) prog_rom(8'($urandom_range(64, 255)), 8'($urandom));
            wr   = 1'($urandom);
            map  = 1'($urandom);
            addr = map ? 8'($urandom_range(0, 79)) : 8'($urandom);
            access(wr, map, addr, 8'($urandom));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, old_v, new_v;
        int acc2, rsp2;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_map = 1'b0;
        req_addr = 8'h00; req_wdata = 8'h00; prog_we = 1'b0; prog_addr = 8'h00;
        prog_data = 8'h00;
        for (int i = 0; i < 256; i++) ram_m[i] = 8'h00;

        #12;
        check_eq("rst_valid1", valid1, 0);
        check_eq("rst_valid2", valid2, 0);
        check_eq("rst_rdata1", rdata1, 0);
        check_eq("rst_rdata2", rdata2, 0);
        check_eq("rst_error1", err1, 0);
        check_eq("rst_error2", err2, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_eq("post_rst_ready1", ready1, 1);
        check_eq("post_rst_ready2", ready2, 1);

        for (int i = 0; i < 256; i++) begin
            prog_we = 1'b1; prog_addr = 8'(i); prog_data = 8'($urandom);
            rom_m[i] = prog_data;
            if (i == 0) begin
                #1;
                check_eq("prog_ready1", ready1, 0);
                check_eq("prog_ready2", ready2, 0);
            end
            @(posedge clk); #1;
        end
        prog_we = 1'b0;

        // Directed RAM / ROM / range cases
        access(1'b0, 1'b1, 8'h06, 8'h00);
        access(1'b1, 1'b1, 8'h05, 8'hA5);
        access(1'b0, 1'b1, 8'h05, 8'h00);
        prog_rom(8'h10, 8'h3C);
        access(1'b0, 1'b0, 8'h10, 8'h00);
        access(1'b1, 1'b0, 8'h10, 8'hFF);
        access(1'b0, 1'b0, 8'h10, 8'h00);
        access(1'b0, 1'b1, 8'h40, 8'h00);
        access(1'b1, 1'b1, 8'h40, 8'h12);
        access(1'b1, 1'b1, 8'hFF, 8'h34);
        access(1'b1, 1'b1, 8'h3F, 8'h11);
        access(1'b0, 1'b1, 8'h3F, 8'h00);

        // Program load blocks a simultaneous request
        req_valid = 1'b1; req_write = 1'b0; req_map = 1'b0; req_addr = 8'h11;
        prog_we = 1'b1; prog_addr = 8'h11; prog_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("block_ready1", ready1, 0);
            check_eq("block_ready2", ready2, 0);
            check_eq("block_valid1", valid1, 0);
            @(posedge clk); #1;
        end
        rom_m[8'h11] = 8'h5A;
        prog_we = 1'b0;
        #1;
        check_eq("unblock_ready1", ready1, 1);
        check_eq("unblock_ready2", ready2, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(1'b0, 8'h5A, 8'h5A);

        // ROM rewritten on the edge where the 1-wait unit samples: it sees old data
        old_v = rom_m[8'h20];
        new_v = ~old_v;
        issue(1'b0, 1'b0, 8'h20, 8'h00);
        prog_we = 1'b1; prog_addr = 8'h20; prog_data = new_v;
        fork
            begin @(posedge clk); #1; prog_we = 1'b0; end
        join_none
        wait_resp(1'b0, old_v, new_v);
        rom_m[8'h20] = new_v;

        // Continuous requests: one accept per WAIT_STATES+2 cycles
        a = 8'($urandom_range(0, 63));
        req_valid = 1'b1; req_write = 1'b0; req_map = 1'b1; req_addr = a;
        acc2 = 0; rsp2 = 0;
        #1;
        for (int s = 0; s < 16; s++) begin
            check_eq("stream_ready1", ready1, (s % 3) == 0);
            check_eq("stream_ready2", ready2, (s % 4) == 0);
            check_eq("stream_valid1", valid1, (s % 3) == 2);
            check_eq("stream_valid2", valid2, (s % 4) == 3);
            if (valid2) check_eq("stream_rdata2", rdata2, ram_m[a]);
            acc2 += int'(ready2);
            rsp2 += int'(valid2);
            @(posedge clk); #1;
        end
        check_eq("stream_accepts2", acc2, 4);
        check_eq("stream_resps2", rsp2, 4);
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        random_accesses(150);

        // Reset during the wait of an in-flight write
        access(1'b1, 1'b1, 8'h02, 8'h77);
        issue(1'b1, 1'b1, 8'h02, 8'h99);
        reset = 1'b1;
        #2;
        check_eq("abort_valid1", valid1, 0);
        check_eq("abort_valid2", valid2, 0);
        check_eq("abort_rdata1", rdata1, 0);
        check_eq("abort_error2", err2, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) ram_m[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            check_eq("abort_quiet1", valid1, 0);
            check_eq("abort_quiet2", valid2, 0);
            @(posedge clk); #1;
        end
        access(1'b0, 1'b1, 8'h02, 8'h00);
        access(1'b0, 1'b0, 8'h10, 8'h00);
        check_eq("rom_kept_model", rom_m[8'h10], 8'h3C);
        access(1'b0, 1'b0, 8'h11, 8'h00);
        random_accesses(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
